// File: rtl/npc_redirect_ctrl_pkg.sv
// npc_redirect_ctrl_pkg: shared pc_mux_sel codes and the redirect FSM state encoding.
package npc_redirect_ctrl_pkg;
   localparam logic [2:0] SEL_SEQ = 3'd0;
   localparam logic [2:0] SEL_BR  = 3'd1;
   localparam logic [2:0] SEL_J   = 3'd2;
   localparam logic [2:0] SEL_JR  = 3'd3;
   localparam logic [2:0] SEL_EPC = 3'd4;
   localparam logic [2:0] SEL_EXC = 3'd5;
   typedef enum logic {IDLE, PEND} state_e;
endpackage

// File: rtl/npc_redirect_ctrl_if.sv
// npc_redirect_ctrl_if: ID/CP0 redirect requests in, fetch-stage next-PC controls out.
//   master: requester/fetch side (drives requests, operands, id_allowin)
//   slave : npc_redirect_ctrl (drives pc_mux_sel, imm_out, rs_pc_out, flush_if_id, redirect_pending)
interface npc_redirect_ctrl_if;
   logic        id_allowin;
   logic        br_req;
   logic        j_req;
   logic        jr_req;
   logic        eret_req;
   logic        exc_req;
   logic [25:0] imm_in;
   logic [31:0] rs_pc_in;
   logic [2:0]  pc_mux_sel;
   logic [25:0] imm_out;
   logic [31:0] rs_pc_out;
   logic        flush_if_id;
   logic        redirect_pending;
   modport master (
      output id_allowin, br_req, j_req, jr_req, eret_req, exc_req, imm_in, rs_pc_in,
      input  pc_mux_sel, imm_out, rs_pc_out, flush_if_id, redirect_pending
   );
   modport slave (
      input  id_allowin, br_req, j_req, jr_req, eret_req, exc_req, imm_in, rs_pc_in,
      output pc_mux_sel, imm_out, rs_pc_out, flush_if_id, redirect_pending
   );
endinterface

// File: rtl/npc_req_prio.sv
// npc_req_prio: fixed-priority encoder exc > eret > jr > j > br -> 3-bit pc_mux_sel code.
//   in : br, j, jr, eret, exc request bits
//   out: sel (SEL_SEQ when no request)
module npc_req_prio
   import npc_redirect_ctrl_pkg::*;
#(
   parameter logic [2:0] EXC_SEL = SEL_EXC
) (
   input  logic       br,
   input  logic       j,
   input  logic       jr,
   input  logic       eret,
   input  logic       exc,
   output logic [2:0] sel
);
   assign sel = exc ? EXC_SEL : eret ? SEL_EPC : jr ? SEL_JR : j ? SEL_J : br ? SEL_BR : SEL_SEQ;
endmodule

// File: rtl/npc_redirect_ctrl.sv
// npc_redirect_ctrl: arbitrates fetch redirects and holds the winner across ID stalls.
//   clk, rst : clock, synchronous active-high reset
//   bus      : npc_redirect_ctrl_if.slave (requests/operands in, pc_mux_sel/flush/pending out)
//   EXC_VEC_SEL : pc_mux_sel code of the exception-vector leg
//   DELAY_SLOT_EN : when defined, br/j/jr redirects keep the delay-slot instruction (no flush)
module npc_redirect_ctrl
   import npc_redirect_ctrl_pkg::*;
#(
   parameter logic [2:0] EXC_VEC_SEL = 3'd5
) (
   input  logic clk,
   input  logic rst,
   npc_redirect_ctrl_if.slave bus
);
   state_e      state, state_n;
   logic [2:0]  kind_q, kind_n, win, ovr, upd, sel;
   logic [25:0] imm_q;
   logic [31:0] rs_q;
   logic        cap;
   npc_req_prio #(.EXC_SEL(EXC_VEC_SEL)) u_win (
      .br(bus.br_req), .j(bus.j_req), .jr(bus.jr_req),
      .eret(bus.eret_req), .exc(bus.exc_req), .sel(win)
   );
   // While pending only exc/eret may replace the held kind; eret never displaces exc.
   npc_req_prio #(.EXC_SEL(EXC_VEC_SEL)) u_ovr (
      .br(1'b0), .j(1'b0), .jr(1'b0),
      .eret(bus.eret_req && kind_q != EXC_VEC_SEL), .exc(bus.exc_req), .sel(ovr)
   );
   assign upd = (ovr != SEL_SEQ) ? ovr : kind_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         kind_q <= SEL_SEQ;
         imm_q  <= '0;
         rs_q   <= '0;
      end else begin
         state  <= state_n;
         kind_q <= kind_n;
         if (cap) begin
            imm_q <= bus.imm_in;
            rs_q  <= bus.rs_pc_in;
         end
      end
   end
   always_comb begin
      state_n              = state;
      kind_n               = kind_q;
      cap                  = 1'b0;
      sel                  = SEL_SEQ;
      bus.imm_out          = bus.imm_in;
      bus.rs_pc_out        = bus.rs_pc_in;
      bus.redirect_pending = 1'b0;
      if (state == IDLE) begin
         sel = bus.id_allowin ? win : SEL_SEQ;
         if (win != SEL_SEQ && !bus.id_allowin) begin
            state_n = PEND;
            kind_n  = win;
            cap     = 1'b1;
         end
      end else begin
         bus.imm_out          = imm_q;
         bus.rs_pc_out        = rs_q;
         bus.redirect_pending = 1'b1;
         sel                  = bus.id_allowin ? upd : kind_q;
         kind_n               = upd;
         state_n              = bus.id_allowin ? IDLE : PEND;
      end
   end
   assign bus.pc_mux_sel = sel;
`ifdef DELAY_SLOT_EN
   assign bus.flush_if_id = bus.id_allowin && (sel == EXC_VEC_SEL || sel == SEL_EPC);
`else
   assign bus.flush_if_id = bus.id_allowin && sel != SEL_SEQ;
`endif
endmodule

// File: doc/npc_redirect_ctrl.md
Name: npc_redirect_ctrl

Overview:
Sequences the fetch-stage next-PC mux. Arbitrates redirect requests (taken branch, j/jal, jr/jalr, eret, exception) arriving from ID and CP0, and drives pc_mux_sel and flush_if_id. When ID is stalled, it latches the winning redirect and its operands so the redirect is applied on the first cycle the PC is allowed to load. Sits between the ID/CP0 stages and the fetch stage's PC/NPC logic.

Parameters:
EXC_VEC_SEL, 3'd5, pc_mux_sel code for the exception-vector input (top level wires the vector onto that mux leg).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
id_allowin  in  1  PC loads at the next edge when 1
br_req  in  1  taken conditional branch in ID (single-cycle pulse)
j_req  in  1  j/jal in ID
jr_req  in  1  jr/jalr in ID
eret_req  in  1  eret from CP0
exc_req  in  1  exception commit from CP0
imm_in  in  26  branch/jump immediate from ID
rs_pc_in  in  32  jr target from ID
pc_mux_sel  out  3  0 seq, 1 branch, 2 jump, 3 jr, 4 epc, EXC_VEC_SEL exception
imm_out  out  26  immediate presented to the fetch stage
rs_pc_out  out  32  jr target presented to the fetch stage
flush_if_id  out  1  kill the IF->ID valid this cycle
redirect_pending  out  1  a latched redirect is waiting for id_allowin

Behaviour:
- Priority among requests asserted in the same cycle: exc > eret > jr > j > br. The winner is "req_win"; if no request is asserted, req_win is SEQ.
- States:
  - IDLE: no redirect is held.
  - PEND: a redirect is held in the kind_q / imm_q / rs_q registers.
- IDLE, no request: pc_mux_sel = 0, flush_if_id = 0, imm_out = imm_in, rs_pc_out = rs_pc_in.
- IDLE, request, id_allowin = 1:
  - Redirect applies the same cycle, combinationally: pc_mux_sel = code(req_win), operands pass through.
  - flush_if_id = 1 (subject to the optional feature).
  - Stay in IDLE; zero added latency.
- IDLE, request, id_allowin = 0:
  - pc_mux_sel = 0 and flush_if_id = 0 this cycle.
  - At the edge, capture kind_q = req_win, imm_q = imm_in, rs_q = rs_pc_in, then go to PEND.
- PEND outputs: pc_mux_sel = code(kind_q), imm_out = imm_q, rs_pc_out = rs_q, redirect_pending = 1.
- PEND, id_allowin = 1: flush_if_id = 1 (subject to the optional feature); at the edge return to IDLE.
- PEND, id_allowin = 0: hold all registers.
- PEND, new request arrives:
  - exc_req always overwrites kind_q.
  - eret_req overwrites kind_q unless kind_q = exc.
  - br/j/jr requests are ignored; ID is frozen, so they are re-presentations of the held request.
  - If id_allowin = 1 in the same cycle, the overwriting kind is applied immediately, combinationally, and the state returns to IDLE.
- Reset: state = IDLE, kind_q = SEQ, imm_q = 0, rs_q = 0.
  - Outputs after reset: pc_mux_sel = 0, flush_if_id = 0, redirect_pending = 0.
  - imm_out and rs_pc_out follow their inputs.
  - Reset mid-PEND discards the held redirect.
- flush_if_id is never asserted while pc_mux_sel = 0.

Optional Feature:
DELAY_SLOT_EN
- Defined:
  - br, j and jr redirects do not assert flush_if_id; the instruction in IF is the architectural delay slot and proceeds to ID.
  - exc and eret still flush.
- Undefined: every redirect asserts flush_if_id when applied (no delay slot).

Decomposition:
- Shared package holds:
  - The pc_mux_sel code constants: SEL_SEQ = 0, SEL_BR = 1, SEL_J = 2, SEL_JR = 3, SEL_EPC = 4, SEL_EXC = 5.
  - The two-state encoding: IDLE, PEND.
- One sub-module, npc_req_prio: a combinational fixed-priority encoder from the five requests to a 3-bit sel code. It is reused for both the IDLE path and the PEND overwrite path.

Test Plan:
1. br_req = 1, id_allowin = 1, imm_in = 26'h0000010 -> same cycle pc_mux_sel = 1, imm_out = 26'h10, flush_if_id = 1 (0 with DELAY_SLOT_EN); next cycle pc_mux_sel = 0.
2. jr_req = 1, rs_pc_in = 32'h0000_0400, id_allowin = 0 for 3 cycles, and rs_pc_in changed to 32'hDEAD_BEEF after the first cycle -> redirect_pending = 1 during the stall, pc_mux_sel = 3, rs_pc_out = 32'h400 throughout; on the id_allowin = 1 cycle flush is per config; then IDLE.
3. br_req, j_req and exc_req together with id_allowin = 1 -> pc_mux_sel = 5, flush_if_id = 1 in both configurations.
4. j_req pending (id_allowin = 0), then exc_req pulses -> pc_mux_sel switches to 5 the next cycle; when id_allowin = 1, flush_if_id = 1; a later eret_req while pending with exc is ignored.
5. rst = 1 asserted while in PEND -> next cycle redirect_pending = 0, pc_mux_sel = 0, flush_if_id = 0.
6. eret_req = 1, id_allowin = 1 -> pc_mux_sel = 4, flush_if_id = 1 in both configurations.
